// File: rtl/psum_writeback.sv
// psum_writeback: write-back stage from the systolic array into the
// double-buffered output buffer. One row of LANES signed partial sums is
// accepted per cycle and either overwrites a bank row or is accumulated into
// it (read in the handshake cycle, saturating add and write one cycle later).
module psum_writeback #(
    parameter int LANES = 8,
    parameter int W     = 16,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic                 buf_select,
    input  logic                 accum,
    input  logic [AW:0]          tile_rows,
    input  logic                 sa_valid,
    input  logic [LANES*W-1:0]   sa_data,
    output logic                 sa_ready,
    output logic                 ob_rd_en,
    output logic                 ob_rd_bank,
    output logic [AW-1:0]        ob_rd_addr,
    input  logic [LANES*W-1:0]   ob_rd_data,
    output logic                 ob_wr_en,
    output logic                 ob_wr_bank,
    output logic [AW-1:0]        ob_wr_addr,
    output logic [LANES*W-1:0]   ob_wr_data,
    output logic                 busy,
    output logic                 done,
    output logic                 sat_flag
);

    localparam logic [1:0]    ST_IDLE  = 2'd0;
    localparam logic [1:0]    ST_RUN   = 2'd1;
    localparam logic [1:0]    ST_LAST  = 2'd2;
    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ROWS_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   ROWS_ZERO = {(AW+1){1'b0}};
    localparam logic [AW-1:0] R_ONE    = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] R_ZERO   = {AW{1'b0}};

    // Signed add in W+1 bits with clamping. Bit W of the result is the
    // clamp indicator, bits W-1:0 the saturated sum.
    function automatic logic [W:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        logic [W:0] r;
        s = {a[W-1], a} + {b[W-1], b};
        if (s[W] != s[W-1]) begin
            if (s[W] == 1'b0) begin
                r = {1'b1, 1'b0, {(W-1){1'b1}}};
            end else begin
                r = {1'b1, 1'b1, {(W-1){1'b0}}};
            end
        end else begin
            r = {1'b0, s[W-1:0]};
        end
        return r;
    endfunction

    // Tile control registers
    logic [1:0]          state_q, state_d;
    logic                bank_q;
    logic                accum_q;
    logic [AW:0]         rows_q;
    logic [AW-1:0]       r_q, r_d;
    logic                sat_q, sat_d;

    // Write pipeline stage
    logic                s1_valid_q;
    logic                s1_accum_q;
    logic                s1_bank_q;
    logic [AW-1:0]       s1_addr_q;
    logic [LANES*W-1:0]  s1_data_q;

    // Combinational helpers
    logic                start_ok_s;
    logic                start_s;
    logic                xfer_s;
    logic                last_row_s;
    logic [LANES*W-1:0]  sum_data_s;
    logic [LANES-1:0]    lane_sat_s;
    logic                any_sat_s;

    // Next-state, row counter and sticky saturation logic
    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        sat_d      = sat_q;
        start_ok_s = en && (tile_rows != ROWS_ZERO) && (tile_rows <= DEPTH_C);
        start_s    = (state_q == ST_IDLE) && start_ok_s;
        xfer_s     = sa_valid && (state_q == ST_RUN);
        last_row_s = ({1'b0, r_q} == (rows_q - ROWS_ONE));
        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (xfer_s && last_row_s) begin
                    state_d = ST_LAST;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_LAST: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Counter holds on the final row so the read address bus stays put
        if (start_s) begin
            r_d = R_ZERO;
        end else if (xfer_s && !last_row_s) begin
            r_d = r_q + R_ONE;
        end else begin
            r_d = r_q;
        end
        if (start_s) begin
            sat_d = 1'b0;
        end else if (any_sat_s) begin
            sat_d = 1'b1;
        end else begin
            sat_d = sat_q;
        end
    end

    // Lane-wise saturating sum of the staged row and the returned bank data
    always_comb begin
        logic [W:0] res;
        res        = {(W+1){1'b0}};
        sum_data_s = {(LANES*W){1'b0}};
        lane_sat_s = {LANES{1'b0}};
        for (int k = 0; k < LANES; k++) begin
            res                     = sat_add(s1_data_q[k*W +: W], ob_rd_data[k*W +: W]);
            sum_data_s[k*W +: W]    = res[W-1:0];
            lane_sat_s[k]           = res[W];
        end
        any_sat_s = s1_valid_q && s1_accum_q && (|lane_sat_s);
    end

    // State, tile configuration and counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            bank_q  <= 1'b0;
            accum_q <= 1'b0;
            rows_q  <= ROWS_ZERO;
            r_q     <= R_ZERO;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            sat_q   <= sat_d;
            if (start_s) begin
                bank_q  <= buf_select;
                accum_q <= accum;
                rows_q  <= tile_rows;
            end
        end
    end

    // Stage 1 register: accepted row and its address, written next cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_accum_q <= 1'b0;
            s1_bank_q  <= 1'b0;
            s1_addr_q  <= R_ZERO;
            s1_data_q  <= {(LANES*W){1'b0}};
        end else begin
            s1_valid_q <= xfer_s;
            if (xfer_s) begin
                s1_accum_q <= accum_q;
                s1_bank_q  <= bank_q;
                s1_addr_q  <= r_q;
                s1_data_q  <= sa_data;
            end
        end
    end

    assign sa_ready   = (state_q == ST_RUN);
    assign ob_rd_en   = xfer_s && accum_q;
    assign ob_rd_bank = bank_q;
    assign ob_rd_addr = r_q;
    assign ob_wr_en   = s1_valid_q;
    assign ob_wr_bank = s1_bank_q;
    assign ob_wr_addr = s1_addr_q;
    assign ob_wr_data = s1_accum_q ? sum_data_s : s1_data_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_LAST);
    assign sat_flag   = sat_q;

endmodule

// File: tb/tb_psum_writeback.sv
// Bench for psum_writeback: behavioural bank memory, transaction monitor and
// a row-level reference model of overwrite / saturating accumulate.
module tb_psum_writeback;
    localparam int LANES = 8;
    localparam int W     = 16;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int DW    = LANES * W;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          en, buf_select, accum, sa_valid;
    logic [AW:0]   tile_rows;
    logic [DW-1:0] sa_data;
    logic          sa_ready, ob_rd_en, ob_rd_bank, ob_wr_en, ob_wr_bank;
    logic [AW-1:0] ob_rd_addr, ob_wr_addr;
    logic [DW-1:0] ob_wr_data;
    logic [DW-1:0] ob_rd_data = '0;
    logic          busy, done, sat_flag;

    logic [DW-1:0] mem [2][DEPTH];
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {int cyc; logic bank; logic [AW-1:0] addr; logic [DW-1:0] data; logic done;} wr_t;
    typedef struct {int cyc; logic bank; logic [AW-1:0] addr;} rd_t;
    typedef struct {logic bank; logic [AW-1:0] addr; logic [DW-1:0] data;} exp_t;
    wr_t  wr_obs[$];
    rd_t  rd_obs[$];
    int   hs_obs[$];
    exp_t exp_q[$];
    int   done_cnt;
    int   rdy_last_cnt;
    bit   exp_sat;
    bit   inject_en;
    logic [DW-1:0] tile_data [DEPTH];
    int            tile_gap  [DEPTH];
    logic [DW-1:0] ref_mem [2][DEPTH];

    psum_writeback #(.LANES(LANES), .W(W), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .buf_select(buf_select), .accum(accum),
        .tile_rows(tile_rows), .sa_valid(sa_valid), .sa_data(sa_data), .sa_ready(sa_ready),
        .ob_rd_en(ob_rd_en), .ob_rd_bank(ob_rd_bank), .ob_rd_addr(ob_rd_addr), .ob_rd_data(ob_rd_data),
        .ob_wr_en(ob_wr_en), .ob_wr_bank(ob_wr_bank), .ob_wr_addr(ob_wr_addr), .ob_wr_data(ob_wr_data),
        .busy(busy), .done(done), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output-buffer bank behaviour: synchronous write, one-cycle read
    always @(posedge clk) begin
        if (ob_wr_en) mem[ob_wr_bank][ob_wr_addr] <= ob_wr_data;
        if (ob_rd_en) ob_rd_data <= mem[ob_rd_bank][ob_rd_addr];
    end

    // Monitor: records handshakes, reads and writes away from the clock edge
    always @(negedge clk) begin
        if (reset_n) begin
            if (sa_valid && sa_ready) hs_obs.push_back(cyc);
            if (ob_rd_en) rd_obs.push_back('{cyc, ob_rd_bank, ob_rd_addr});
            if (ob_wr_en) wr_obs.push_back('{cyc, ob_wr_bank, ob_wr_addr, ob_wr_data, done});
            if (done) done_cnt++;
            if (done && sa_ready) rdy_last_cnt++;
        end
    end

    function automatic logic [DW-1:0] rnd_row();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference model: row results from plain integer arithmetic
    task automatic model_tile(input logic bank, input logic acc, input int rows);
        exp_sat = 1'b0;
        for (int i = 0; i < rows; i++) begin
            logic [DW-1:0] res;
            res = '0;
            for (int k = 0; k < LANES; k++) begin
                int s;
                s = $signed(tile_data[i][k*W +: W]);
                if (acc) s = s + $signed(ref_mem[bank][i][k*W +: W]);
                if (s > 32767) begin
                    s = 32767; exp_sat = 1'b1;
                end else if (s < -32768) begin
                    s = -32768; exp_sat = 1'b1;
                end
                res[k*W +: W] = s[15:0];
            end
            ref_mem[bank][i] = res;
            exp_q.push_back('{bank, AW'(i), res});
        end
    endtask

    task automatic clear_obs();
        wr_obs.delete(); rd_obs.delete(); hs_obs.delete(); exp_q.delete();
        done_cnt = 0; rdy_last_cnt = 0;
    endtask

    // Drive one tile using tile_data/tile_gap; no checking here apart from
    // the bounded wait for sa_ready
    task automatic run_tile(input logic bank, input logic acc, input int rows);
        clear_obs();
        model_tile(bank, acc, rows);
        @(posedge clk); #1;
        en = 1'b1; buf_select = bank; accum = acc; tile_rows = 6'(rows);
        @(posedge clk); #1;
        en = 1'b0; buf_select = ~bank; accum = ~acc; tile_rows = 6'($urandom_range(0, 63));
        for (int i = 0; i < rows; i++) begin
            for (int g = 0; g < tile_gap[i]; g++) begin
                sa_valid = 1'b0; sa_data = rnd_row();
                en = inject_en;
                if (inject_en) tile_rows = 6'(rows);
                @(posedge clk); #1;
                en = 1'b0;
            end
            sa_valid = 1'b1; sa_data = tile_data[i];
            for (int w = 0; w < 8 && !sa_ready; w++) begin
                @(posedge clk); #1;
            end
            checks++;
            if (sa_ready !== 1'b1) begin
                failures++; $display("FAIL ready_timeout row=%0d got=%b exp=1", i, sa_ready);
            end
            @(posedge clk); #1;
        end
        sa_data = rnd_row();
        @(posedge clk); #1;
        sa_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; en = 1'b0; buf_select = 1'b0; accum = 1'b0; tile_rows = '0;
        sa_valid = 1'b0; sa_data = '0; inject_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({sa_ready, ob_rd_en, ob_wr_en, busy, done, sat_flag, ob_rd_bank, ob_rd_addr,
             ob_wr_bank, ob_wr_addr, ob_wr_data} !== '0) begin
            failures++; $display("FAIL reset_outputs got=%h exp=0", {busy, done, ob_wr_en, ob_wr_data});
        end
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_overwrite();
        for (int r = 0; r < 4; r++) begin
            tile_gap[r] = 0;
            for (int k = 0; k < LANES; k++) tile_data[r][k*W +: W] = 16'(r*16 + k);
        end
        run_tile(1'b1, 1'b0, 4);
        checks++;
        if (wr_obs.size() != 4) begin
            failures++; $display("FAIL ovw_count got=%0d exp=4", wr_obs.size());
        end
        for (int i = 0; i < 4 && i < wr_obs.size() && i < hs_obs.size(); i++) begin
            checks++;
            if (wr_obs[i].addr !== exp_q[i].addr || wr_obs[i].bank !== 1'b1 || wr_obs[i].data !== exp_q[i].data) begin
                failures++; $display("FAIL ovw_write i=%0d got=%0d/%0d/%h exp=%0d/1/%h", i, wr_obs[i].bank,
                                     wr_obs[i].addr, wr_obs[i].data, exp_q[i].addr, exp_q[i].data);
            end
            checks++;
            if (wr_obs[i].cyc !== hs_obs[i] + 1) begin
                failures++; $display("FAIL ovw_latency i=%0d got=%0d exp=%0d", i, wr_obs[i].cyc, hs_obs[i] + 1);
            end
            checks++;
            if (wr_obs[i].done !== (i == 3)) begin
                failures++; $display("FAIL ovw_done i=%0d got=%b exp=%b", i, wr_obs[i].done, (i == 3));
            end
        end
        checks++;
        if (rd_obs.size() != 0 || done_cnt != 1 || busy !== 1'b0) begin
            failures++; $display("FAIL ovw_misc got=rd%0d/done%0d/busy%b exp=rd0/done1/busy0",
                                 rd_obs.size(), done_cnt, busy);
        end
    endtask

    task automatic test_saturation();
        tile_gap[0] = 0;
        tile_data[0] = {8{16'h7F00}};
        run_tile(1'b1, 1'b0, 1);
        for (int k = 0; k < LANES; k++) tile_data[0][k*W +: W] = (k == 3) ? 16'h0200 : 16'hFF00;
        run_tile(1'b1, 1'b1, 1);
        checks++;
        if (wr_obs.size() != 1 || wr_obs[0].data !== {16'h7E00, 16'h7E00, 16'h7E00, 16'h7E00,
                                                       16'h7FFF, 16'h7E00, 16'h7E00, 16'h7E00}) begin
            failures++; $display("FAIL sat_pos got=%h exp lane3=7fff others=7e00", wr_obs[0].data);
        end
        checks++;
        if (sat_flag !== 1'b1) begin
            failures++; $display("FAIL sat_pos_flag got=%b exp=1", sat_flag);
        end
        tile_data[0] = {8{16'h8000}};
        run_tile(1'b0, 1'b0, 1);
        tile_data[0] = {8{16'hFFFF}};
        run_tile(1'b0, 1'b1, 1);
        checks++;
        if (wr_obs.size() != 1 || wr_obs[0].data !== exp_q[0].data || sat_flag !== exp_sat) begin
            failures++; $display("FAIL sat_neg got=%h/%b exp=%h/%b", wr_obs[0].data, sat_flag, exp_q[0].data, exp_sat);
        end
    endtask

    task automatic test_accumulate();
        tile_gap[0] = 0; tile_gap[1] = 0;
        tile_data[0] = {8{16'd100}}; tile_data[1] = {8{16'd100}};
        run_tile(1'b0, 1'b0, 2);
        checks++;
        if (sat_flag !== 1'b0) begin
            failures++; $display("FAIL sat_clear got=%b exp=0", sat_flag);
        end
        tile_data[0] = {8{16'd5}}; tile_data[1] = {8{16'hFF38}};
        run_tile(1'b0, 1'b1, 2);
        checks++;
        if (wr_obs.size() != 2 || rd_obs.size() != 2 || hs_obs.size() != 2) begin
            failures++; $display("FAIL acc_count got=wr%0d/rd%0d/hs%0d exp=2/2/2", wr_obs.size(), rd_obs.size(), hs_obs.size());
        end
        for (int i = 0; i < 2 && i < wr_obs.size() && i < rd_obs.size() && i < hs_obs.size(); i++) begin
            checks++;
            if (wr_obs[i].data !== exp_q[i].data || wr_obs[i].addr !== AW'(i) || wr_obs[i].bank !== 1'b0) begin
                failures++; $display("FAIL acc_write i=%0d got=%h exp=%h", i, wr_obs[i].data, exp_q[i].data);
            end
            checks++;
            if (rd_obs[i].cyc !== hs_obs[i] || rd_obs[i].addr !== AW'(i) || rd_obs[i].bank !== 1'b0) begin
                failures++; $display("FAIL acc_read i=%0d got=%0d@%0d exp=%0d@%0d", i, rd_obs[i].addr,
                                     rd_obs[i].cyc, i, hs_obs[i]);
            end
        end
        checks++;
        if (sat_flag !== 1'b0) begin
            failures++; $display("FAIL acc_flag got=%b exp=0", sat_flag);
        end
    endtask

    task automatic test_bubbles();
        tile_gap[0] = 0; tile_gap[1] = 2; tile_gap[2] = 0;
        for (int i = 0; i < 3; i++) tile_data[i] = rnd_row();
        inject_en = 1'b1;
        run_tile(1'b0, 1'b0, 3);
        inject_en = 1'b0;
        checks++;
        if (wr_obs.size() != 3 || hs_obs.size() != 3 || done_cnt != 1 || rdy_last_cnt != 0) begin
            failures++; $display("FAIL bub_counts got=wr%0d/hs%0d/done%0d/rdylast%0d exp=3/3/1/0",
                                 wr_obs.size(), hs_obs.size(), done_cnt, rdy_last_cnt);
        end
        for (int i = 0; i < 3 && i < wr_obs.size() && i < hs_obs.size(); i++) begin
            checks++;
            if (wr_obs[i].addr !== AW'(i) || wr_obs[i].data !== exp_q[i].data || wr_obs[i].cyc !== hs_obs[i] + 1) begin
                failures++; $display("FAIL bub_write i=%0d got=%0d/%h exp=%0d/%h", i, wr_obs[i].addr,
                                     wr_obs[i].data, i, exp_q[i].data);
            end
        end
    endtask

    task automatic test_random();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < DEPTH; i++) begin
                tile_data[i] = rnd_row(); tile_gap[i] = int'($urandom_range(0, 1));
            end
            run_tile(1'(b), 1'b0, DEPTH);
            checks++;
            if (wr_obs.size() != DEPTH || wr_obs[DEPTH-1].addr !== AW'(DEPTH-1) || wr_obs[DEPTH-1].data !== exp_q[DEPTH-1].data) begin
                failures++; $display("FAIL full_depth bank=%0d got=%0d writes exp=%0d", b, wr_obs.size(), DEPTH);
            end
        end
        for (int t = 0; t < 8; t++) begin
            logic bk, ac;
            int   rows;
            bk = 1'($urandom_range(0, 1)); ac = 1'($urandom_range(0, 1));
            rows = int'($urandom_range(1, 8));
            if (t == 7) begin rows = DEPTH; ac = 1'b1; end
            for (int i = 0; i < rows; i++) begin
                tile_gap[i] = int'($urandom_range(0, 2));
                for (int k = 0; k < LANES; k++)
                    tile_data[i][k*W +: W] = (t % 2 == 1) ? 16'($urandom()) : 16'($urandom_range(0, 2047)) - 16'd1024;
            end
            run_tile(bk, ac, rows);
            checks++;
            if (wr_obs.size() != rows || rd_obs.size() != (ac ? rows : 0)) begin
                failures++; $display("FAIL rnd_count t=%0d got=wr%0d/rd%0d exp=%0d/%0d", t, wr_obs.size(),
                                     rd_obs.size(), rows, ac ? rows : 0);
            end
            for (int i = 0; i < rows && i < wr_obs.size(); i++) begin
                checks++;
                if (wr_obs[i].data !== exp_q[i].data || wr_obs[i].addr !== exp_q[i].addr || wr_obs[i].bank !== bk) begin
                    failures++; $display("FAIL rnd_write t=%0d i=%0d got=%h exp=%h", t, i, wr_obs[i].data, exp_q[i].data);
                end
            end
            checks++;
            if (sat_flag !== exp_sat) begin
                failures++; $display("FAIL rnd_sat t=%0d got=%b exp=%b", t, sat_flag, exp_sat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] a0, a1, b0, b1;
        clear_obs();
        a0 = rnd_row(); a1 = rnd_row(); b0 = rnd_row(); b1 = rnd_row();
        tile_data[0] = a0; tile_data[1] = a1; model_tile(1'b0, 1'b0, 2);
        tile_data[0] = b0; tile_data[1] = b1; model_tile(1'b1, 1'b1, 2);
        @(posedge clk); #1;
        en = 1'b1; buf_select = 1'b0; accum = 1'b0; tile_rows = 6'd2;
        @(posedge clk); #1; en = 1'b0; sa_valid = 1'b1; sa_data = a0;
        @(posedge clk); #1; sa_data = a1;
        @(posedge clk); #1; sa_valid = 1'b0;
        @(posedge clk); #1; en = 1'b1; buf_select = 1'b1; accum = 1'b1; tile_rows = 6'd2;
        @(posedge clk); #1; en = 1'b0; sa_valid = 1'b1; sa_data = b0;
        @(posedge clk); #1; sa_data = b1;
        @(posedge clk); #1; sa_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (hs_obs.size() != 4 || hs_obs[2] - hs_obs[1] != 3 || done_cnt != 2 || rd_obs.size() != 2) begin
            failures++; $display("FAIL b2b_timing got=hs%0d gap%0d done%0d rd%0d exp=4/3/2/2",
                                 hs_obs.size(), hs_obs[2] - hs_obs[1], done_cnt, rd_obs.size());
        end
        checks++;
        if (wr_obs.size() != 4) begin
            failures++; $display("FAIL b2b_count got=%0d exp=4", wr_obs.size());
        end
        for (int i = 0; i < 4 && i < wr_obs.size(); i++) begin
            checks++;
            if (wr_obs[i].bank !== exp_q[i].bank || wr_obs[i].addr !== exp_q[i].addr || wr_obs[i].data !== exp_q[i].data) begin
                failures++; $display("FAIL b2b_write i=%0d got=%0d/%0d/%h exp=%0d/%0d/%h", i, wr_obs[i].bank,
                                     wr_obs[i].addr, wr_obs[i].data, exp_q[i].bank, exp_q[i].addr, exp_q[i].data);
            end
        end
    endtask

    task automatic test_bad_start();
        logic [AW:0] bad [2];
        bad[0] = 6'd0; bad[1] = 6'd33;
        for (int j = 0; j < 2; j++) begin
            int busy_hi;
            clear_obs();
            busy_hi = 0;
            @(posedge clk); #1;
            en = 1'b1; tile_rows = bad[j]; sa_valid = 1'b1; sa_data = rnd_row();
            @(posedge clk); #1; en = 1'b0;
            for (int c = 0; c < 4; c++) begin
                if (busy !== 1'b0) busy_hi++;
                @(posedge clk); #1;
            end
            sa_valid = 1'b0;
            checks++;
            if (busy_hi != 0 || wr_obs.size() + rd_obs.size() + hs_obs.size() != 0) begin
                failures++; $display("FAIL bad_start rows=%0d got=busy%0d/wr%0d/rd%0d/hs%0d exp=0/0/0/0",
                                     bad[j], busy_hi, wr_obs.size(), rd_obs.size(), hs_obs.size());
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d [4];
        clear_obs();
        for (int i = 0; i < 4; i++) d[i] = rnd_row();
        @(posedge clk); #1;
        en = 1'b1; buf_select = 1'b1; accum = 1'b0; tile_rows = 6'd4;
        @(posedge clk); #1; en = 1'b0; sa_valid = 1'b1; sa_data = d[0];
        @(posedge clk); #1; sa_data = d[1];
        @(posedge clk); #1; sa_data = d[2];
        #1; reset_n = 1'b0;
        #1;
        checks++;
        if ({sa_ready, ob_rd_en, ob_wr_en, busy, done, sat_flag, ob_rd_bank, ob_rd_addr,
             ob_wr_bank, ob_wr_addr, ob_wr_data} !== '0) begin
            failures++; $display("FAIL rst_mid_outputs got=busy%b wr%b addr%0d data=%h exp=0",
                                 busy, ob_wr_en, ob_wr_addr, ob_wr_data);
        end
        repeat (2) @(posedge clk);
        #1; reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1; sa_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (wr_obs.size() != 1 || wr_obs[0].addr !== '0 || wr_obs[0].data !== d[0] || busy !== 1'b0) begin
            failures++; $display("FAIL rst_mid_writes got=%0d writes busy=%b exp=1 write to addr 0, busy 0",
                                 wr_obs.size(), busy);
        end
        ref_mem[1][0] = d[0];
        tile_gap[0] = 0; tile_gap[1] = 1;
        tile_data[0] = rnd_row(); tile_data[1] = rnd_row();
        run_tile(1'b1, 1'b0, 2);
        checks++;
        if (wr_obs.size() != 2 || wr_obs[0].addr !== '0 || wr_obs[0].data !== exp_q[0].data ||
            wr_obs[1].addr !== AW'(1)) begin
            failures++; $display("FAIL rst_restart got=%0d writes first addr=%0d exp=2 writes from addr 0",
                                 wr_obs.size(), wr_obs[0].addr);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_overwrite();
        test_saturation();
        test_accumulate();
        test_bubbles();
        test_random();
        test_back_to_back();
        test_bad_start();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/psum_writeback.md
# psum_writeback

Write-back stage between the systolic array outputs and the double-buffered output buffer: the return path to the input prefetcher, which reads the same banks back through its 16-to-8-bit cutting stage. Accepts one row of LANES signed 16-bit partial sums per cycle over a valid/ready handshake. Either overwrites a bank row or accumulates into it with a read-modify-write using signed saturation. Writes the result to the bank chosen by `buf_select`.

## Interface
- `LANES`, 8: PE columns per row.
- `W`, 16: partial-sum width, signed two's complement.
- `DEPTH`, 32: rows per output-buffer bank.
- `AW`, 5: row address width (log2 DEPTH).
- `clk` in 1: single clock; all logic on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `en` in 1: start strobe, sampled in IDLE only.
- `buf_select` in 1: target bank, latched at start.
- `accum` in 1: 1 = add to existing bank contents, 0 = overwrite; latched at start.
- `tile_rows` in AW+1: number of rows in this tile, valid range 1..DEPTH; latched at start.
- `sa_valid` in 1: array row valid.
- `sa_data` in LANES*W: lane k occupies bits [k*W +: W].
- `sa_ready` out 1: block accepts a row this cycle.
- `ob_rd_en`, `ob_rd_bank`, `ob_rd_addr` out 1/1/AW: bank read request.
- `ob_rd_data` in LANES*W: read data, returned exactly 1 cycle after `ob_rd_en`.
- `ob_wr_en`, `ob_wr_bank`, `ob_wr_addr`, `ob_wr_data` out 1/1/AW/LANES*W: bank write.
- `busy` out 1: high in RUN and LAST.
- `done` out 1: one-cycle pulse marking the final write.
- `sat_flag` out 1: sticky; set when any lane saturated during the current tile.

## Operation
- **States:**
  - IDLE → RUN when `en`=1 and 1 ≤ `tile_rows` ≤ DEPTH.
  - A start with `tile_rows`=0 or `tile_rows` > DEPTH is ignored; the block stays in IDLE.
  - RUN → LAST on the handshake of row `tile_rows`-1.
  - LAST → IDLE unconditionally.
- **At start:**
  - Latch `buf_select`, `accum` and `tile_rows`.
  - Clear the row counter `r` and `sat_flag`.
- **`en` outside IDLE** is ignored.
- **Handshake:**
  - `sa_ready` = 1 in RUN, 0 in IDLE and LAST.
  - A beat transfers when `sa_valid` & `sa_ready`.
  - Bubbles (`sa_valid`=0) are allowed anywhere inside a tile; `r` advances only on a transfer.
- **Accepted beat at row `r`:**
  - Register `sa_data` and `r` (pipeline stage 1).
  - If `accum`=1, assert `ob_rd_en` with `ob_rd_addr`=`r` and `ob_rd_bank` = latched bank in the same cycle.
- **Stage 2 (next cycle):**
  - `ob_wr_en`=1, `ob_wr_addr` = registered `r`.
  - `ob_wr_data` = registered data when `accum`=0.
  - When `accum`=1, `ob_wr_data` = lane-wise `sat16(data + ob_rd_data)`.
- **Saturation:**
  - Add in W+1 bits; positive overflow clamps to 16'h7FFF, negative overflow to 16'h8000.
  - Any clamp sets `sat_flag`.
- **No hazards:** rows within a tile are strictly increasing, so a read never targets a row awaiting write.
- **Reset (asynchronous, including mid-tile):**
  - State goes to IDLE; `r` and the pipeline are cleared.
  - All outputs go to 0: `sa_ready`, `ob_rd_en`, `ob_wr_en`, `busy`, `done`, `sat_flag`, and all address, bank and data buses.
  - The partial tile is abandoned and no further writes are issued.

## Timing
- **Latency:** handshake in cycle t → write in cycle t+1; one row per cycle at full throughput.
- **`done`:** high in the cycle of the last-row write (state LAST); `busy` drops the following cycle.
- **Back-to-back tiles:** minimum gap between the last handshake of one tile and the first of the next is 2 cycles (LAST, then the IDLE start cycle).
- **Idle outputs:** `ob_rd_en` and `ob_wr_en` are 0 whenever no transfer is in flight; buses hold their last value.

## Test plan
- **Overwrite:**
  - Stimulus: `tile_rows`=4, `accum`=0, bank 1, lane k of row r = r*16+k, continuous valid.
  - Required: writes to addresses 0..3 in bank 1, each 1 cycle after its handshake; `done` high with the addr-3 write; `ob_rd_en` never high.
- **Accumulate:**
  - Stimulus: bank 0 preloaded with 100 in every lane; `accum`=1, `tile_rows`=2, data 5 and −200.
  - Required: written values 105 and −100; `ob_rd_en` coincides with each handshake.
- **Saturation:**
  - Stimulus: preload 16'h7F00; accumulate 16'h0200 in lane 3 and −16'h0100 elsewhere.
  - Required: lane 3 = 16'h7FFF, other lanes = 16'h7E00, `sat_flag`=1.
  - Stimulus (negative): preload 16'h8000, accumulate −1.
  - Required: 16'h8000.
- **Bubbles and back-pressure:**
  - Stimulus: valid pattern 1,0,0,1,1 with `tile_rows`=3.
  - Required: addresses 0,1,2 written with no gaps skipped; `sa_ready`=0 in LAST; a second `en` during RUN is ignored.
- **Bad start:**
  - Stimulus: `tile_rows`=0, then 33.
  - Required: `busy` stays 0, no reads or writes.
- **Reset mid-tile:**
  - Stimulus: assert `reset_n`=0 asynchronously after row 1 of 4.
  - Required: all outputs 0 immediately; no write for rows 2..3; a fresh start afterwards writes from address 0.
